// File: rtl/serial_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : serial_restoring_divider
// Purpose  : Multi-cycle unsigned restoring divider. One shift-and-subtract
//            iteration per clock. Each iteration uses a WIDTH+1-bit ripple
//            chain of full-subtractor cells. The final borrow-out decides
//            whether the partial remainder is restored or kept.
// Ports    : clk          - clock, rising edge
//            rst_n        - asynchronous active-low reset
//            start        - operation request, sampled only in IDLE
//            dividend     - unsigned dividend, sampled with start
//            divisor      - unsigned divisor, sampled with start
//            busy         - high whenever the FSM is not in IDLE
//            done         - one-cycle pulse, results valid
//            quotient     - registered quotient
//            remainder    - registered remainder
//            div_by_zero  - registered, set together with done when divisor==0
// Revision : 1.0 - initial release
// ============================================================================
module serial_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_rem;      // partial remainder R
    logic [WIDTH-1:0] r_q;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] r_div;      // divisor captured at start
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    // ------------------------------------------------------------------
    // Shift-in and borrow-chain subtract: {bout,diff} = Rs - {0,divisor}
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_rs;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH+1:0] w_borrow;
    logic             w_bout;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_q_next;

    assign w_rs        = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_sub       = {1'b0, r_div};
    assign w_borrow[0] = 1'b0;

    generate
        for (genvar i = 0; i <= WIDTH; i++) begin : g_fs
            assign w_diff[i]     = w_rs[i] ^ w_sub[i] ^ w_borrow[i];
            assign w_borrow[i+1] = (~w_rs[i] & w_sub[i]) |
                                   (~(w_rs[i] ^ w_sub[i]) & w_borrow[i]);
        end
    endgenerate

    assign w_bout     = w_borrow[WIDTH+1];
    // A borrow means the divisor did not fit: keep the shifted value.
    assign w_rem_next = w_bout ? w_rs : w_diff;
    assign w_q_next   = {r_q[WIDTH-2:0], ~w_bout};

    // After each restore R < divisor, so the top bit of R never feeds the
    // next shift; it exists only so the subtract is WIDTH+1 bits wide.
    logic w_unused_rem_msb;
    assign w_unused_rem_msb = r_rem[WIDTH];

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (divisor == '0) begin
                            // Resolved immediately; no iterations needed.
                            r_quotient  <= {WIDTH{1'b1}};
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_q     <= dividend;
                            r_rem   <= '0;
                            r_div   <= divisor;
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + C_ONE;
                    if (r_cnt == C_LAST) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_serial_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_restoring_divider
// Purpose  : Self-checking bench for serial_restoring_divider (WIDTH=4).
//            Expected results come from plain / and % arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_restoring_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    serial_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic.
    function automatic logic [W-1:0] ref_q(input int a, input int b);
        return (b == 0) ? W'((1 << W) - 1) : W'(a / b);
    endfunction

    function automatic logic [W-1:0] ref_r(input int a, input int b);
        return (b == 0) ? W'(a) : W'(a % b);
    endfunction

    // Edges from start sample (E0 counted as 1) until done is seen.
    function automatic int ref_lat(input int b);
        return (b == 0) ? 1 : W + 1;
    endfunction

    // Runs one operation from IDLE; returns captured results and timing facts.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat,
                          output logic pulse_ok, output logic hold_ok);
        logic [W-1:0] pq, pr;
        logic         pz;
        pq = quotient; pr = remainder; pz = div_by_zero;
        hold_ok  = 1'b1;
        pulse_ok = 1'b1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (quotient !== pq || remainder !== pr || div_by_zero !== pz || busy !== 1'b1)
                hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        q = quotient; r = remainder; z = div_by_zero;
        @(posedge clk); #1;
        if (done !== 1'b0 || busy !== 1'b0) pulse_ok = 1'b0;
    endtask

    task automatic check_op(input string name, input int a, input int b);
        logic [W-1:0] q, r;
        logic z, pok, hok;
        int lat;
        run_op(W'(a), W'(b), q, r, z, lat, pok, hok);
        checks++;
        if (q !== ref_q(a, b) || r !== ref_r(a, b) || z !== (b == 0)) begin
            errors++;
            $display("FAIL %s %0d/%0d: got q=%0d r=%0d z=%0b, want q=%0d r=%0d z=%0b",
                     name, a, b, q, r, z, ref_q(a, b), ref_r(a, b), b == 0);
        end
        checks++;
        if (lat != ref_lat(b) || !pok || !hok) begin
            errors++;
            $display("FAIL %s_timing %0d/%0d: got lat=%0d pulse_ok=%0b hold_ok=%0b, want lat=%0d pulse_ok=1 hold_ok=1",
                     name, a, b, lat, pok, hok, ref_lat(b));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b q=%0d r=%0d z=%0b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%0b done=%0b, want 0 0", busy, done);
        end
    endtask

    // 15/4 with cycle-by-cycle observation of busy/done.
    task automatic test_latency();
        int done_edge = -1;
        dividend = 4'd15; divisor = 4'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL latency_busy_e0: got busy=%0b done=%0b, want 1 0", busy, done);
        end
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1 && done_edge < 0) begin
                done_edge = e;
                checks++;
                if (quotient !== 4'd3 || remainder !== 4'd3 || div_by_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_result: got q=%0d r=%0d z=%0b, want 3 3 0",
                             quotient, remainder, div_by_zero);
                end
            end
        end
        checks++;
        if (done_edge != W || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL latency_edge: got done at E%0d busy=%0b done=%0b, want E%0d 0 0",
                     done_edge, busy, done, W);
        end
    endtask

    task automatic test_div_zero();
        int busy_cycles = 0;
        dividend = 4'd9; divisor = 4'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (done !== 1'b1 || quotient !== 4'hF || remainder !== 4'd9 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_zero: got done=%0b q=%0h r=%0d z=%0b, want 1 f 9 1",
                     done, quotient, remainder, div_by_zero);
        end
        while (busy === 1'b1 && busy_cycles < 10) begin
            busy_cycles++;
            @(posedge clk); #1;
        end
        checks++;
        if (busy_cycles != 1) begin
            errors++;
            $display("FAIL div_zero_busy: got %0d busy cycles, want 1", busy_cycles);
        end
    endtask

    task automatic test_edge_cases();
        check_op("edge_small", 2, 8);
        check_op("edge_by_one", 15, 1);
        check_op("edge_zero_num", 0, 7);
        check_op("edge_equal", 9, 9);
    endtask

    task automatic test_ignore_start();
        int guard = 0;
        dividend = 4'd15; divisor = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        // Start held into CALC with different operands.
        dividend = 4'd6; divisor = 4'd2;
        @(posedge clk); #1; start = 1'b0;
        while (done !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        // In DONE: pulse start again across the DONE edge.
        start = 1'b1;
        checks++;
        if (done !== 1'b1 || quotient !== 4'd3 || remainder !== 4'd3) begin
            errors++;
            $display("FAIL ignore_result: got done=%0b q=%0d r=%0d, want 1 3 3",
                     done, quotient, remainder);
        end
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 4'd3 || remainder !== 4'd3) begin
            errors++;
            $display("FAIL ignore_not_latched: got busy=%0b done=%0b q=%0d r=%0d, want 0 0 3 3",
                     busy, done, quotient, remainder);
        end
        check_op("ignore_followup", 6, 2);
    endtask

    task automatic test_abort();
        int seen_done = 0;
        dividend = 4'd13; divisor = 4'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;   // E0
        @(posedge clk); #1;                 // E1
        @(posedge clk); #2;                 // E2
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%0b done=%0b q=%0d r=%0d z=%0b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done++;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done/busy cycles, want 0", seen_done);
        end
        check_op("abort_rerun", 13, 5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int a, b;
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            check_op("random", a, b);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                check_op("exhaustive", a, b);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_div_zero();
        test_edge_cases();
        test_ignore_start();
        test_abort();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
